// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipelined MIPS control: ID decode, ID/EX/MEM/WB control registers,
// load-use stall, taken-branch flush and sticky illegal-opcode flag.
module pipe_ctrl_unit #(
  parameter int OPW     = 6,
  parameter int AOPW    = 3,
  parameter int RAW     = 5,
  parameter int JUMP_EN = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OPW-1:0]  id_op,
  input  logic            id_valid,
  input  logic [RAW-1:0]  id_rs,
  input  logic [RAW-1:0]  id_rt,
  input  logic            mem_zero,
  output logic            ex_regds,
  output logic            ex_alusrc,
  output logic [AOPW-1:0] ex_aop,
  output logic            ex_jump,
  output logic            mem_branch,
  output logic            mem_mread,
  output logic            mem_mwrite,
  output logic            wb_mtor,
  output logic            wb_urw,
  output logic            stall,
  output logic            flush,
  output logic            illegal
);

  localparam logic [OPW-1:0] OP_R    = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW   = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(6'b001000);
  localparam logic [OPW-1:0] OP_ANDI = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI  = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_SLTI = OPW'(6'b001010);
  localparam logic [OPW-1:0] OP_J    = OPW'(6'b000010);

  logic            dec_regds, dec_branch, dec_mread, dec_mtor;
  logic            dec_mwrite, dec_alusrc, dec_urw, dec_jump;
  logic [AOPW-1:0] dec_aop;
  logic            dec_known, dec_illegal;

  always_comb begin
    dec_regds  = 1'b0;
    dec_branch = 1'b0;
    dec_mread  = 1'b0;
    dec_mtor   = 1'b0;
    dec_aop    = '0;
    dec_mwrite = 1'b0;
    dec_alusrc = 1'b0;
    dec_urw    = 1'b0;
    dec_jump   = 1'b0;
    dec_known  = 1'b1;
    case (id_op)
      OP_R:    begin dec_regds = 1'b1; dec_mtor = 1'b1; dec_aop = AOPW'(3'b010); dec_urw = 1'b1; end
      OP_LW:   begin dec_mread = 1'b1; dec_mtor = 1'b1; dec_aop = AOPW'(3'b011);
                     dec_alusrc = 1'b1; dec_urw = 1'b1; end
      OP_SW:   begin dec_aop = AOPW'(3'b011); dec_mwrite = 1'b1; dec_alusrc = 1'b1; end
      OP_BEQ:  begin dec_branch = 1'b1; dec_aop = AOPW'(3'b001); end
      OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
        dec_regds  = 1'b1;
        dec_mtor   = 1'b1;
        dec_alusrc = 1'b1;
        dec_urw    = 1'b1;
        case (id_op)
          OP_ANDI: dec_aop = AOPW'(3'b101);
          OP_ORI:  dec_aop = AOPW'(3'b110);
          OP_SLTI: dec_aop = AOPW'(3'b100);
          default: dec_aop = AOPW'(3'b011);
        endcase
      end
      OP_J: begin
        if (JUMP_EN != 0) dec_jump = 1'b1;
        else              dec_known = 1'b0;
      end
      default: dec_known = 1'b0;
    endcase
    // An empty ID slot is a NOP regardless of whatever opcode bits are floating there.
    if (!id_valid) begin
      dec_regds  = 1'b0;
      dec_branch = 1'b0;
      dec_mread  = 1'b0;
      dec_mtor   = 1'b0;
      dec_aop    = '0;
      dec_mwrite = 1'b0;
      dec_alusrc = 1'b0;
      dec_urw    = 1'b0;
      dec_jump   = 1'b0;
    end
  end

  assign dec_illegal = id_valid & ~dec_known;

  logic            ex_regds_q, ex_alusrc_q, ex_jump_q, ex_branch_q, ex_mread_q;
  logic            ex_mwrite_q, ex_mtor_q, ex_urw_q, ex_valid_q;
  logic [AOPW-1:0] ex_aop_q;
  logic [RAW-1:0]  ex_rt_q;
  logic            mem_branch_q, mem_mread_q, mem_mwrite_q, mem_mtor_q, mem_urw_q;
  logic            wb_mtor_q, wb_urw_q, illegal_q;

  logic            ex_regds_d, ex_alusrc_d, ex_jump_d, ex_branch_d, ex_mread_d;
  logic            ex_mwrite_d, ex_mtor_d, ex_urw_d, ex_valid_d;
  logic [AOPW-1:0] ex_aop_d;
  logic [RAW-1:0]  ex_rt_d;
  logic            mem_branch_d, mem_mread_d, mem_mwrite_d, mem_mtor_d, mem_urw_d;
  logic            wb_mtor_d, wb_urw_d, illegal_d;
  logic            bubble;

  assign flush  = mem_branch_q & mem_zero;
  assign stall  = ~flush & ex_valid_q & ex_mread_q & id_valid & (ex_rt_q != '0) &
                  ((ex_rt_q == id_rs) | (ex_rt_q == id_rt));
  assign bubble = stall | flush;

  always_comb begin
    ex_regds_d  = bubble ? 1'b0 : dec_regds;
    ex_alusrc_d = bubble ? 1'b0 : dec_alusrc;
    ex_aop_d    = bubble ? '0   : dec_aop;
    ex_jump_d   = bubble ? 1'b0 : dec_jump;
    ex_branch_d = bubble ? 1'b0 : dec_branch;
    ex_mread_d  = bubble ? 1'b0 : dec_mread;
    ex_mwrite_d = bubble ? 1'b0 : dec_mwrite;
    ex_mtor_d   = bubble ? 1'b0 : dec_mtor;
    ex_urw_d    = bubble ? 1'b0 : dec_urw;
    ex_valid_d  = bubble ? 1'b0 : id_valid;
    ex_rt_d     = bubble ? '0   : id_rt;
    // The instruction behind a taken branch is squashed; the branch itself retires into WB.
    mem_branch_d = flush ? 1'b0 : ex_branch_q;
    mem_mread_d  = flush ? 1'b0 : ex_mread_q;
    mem_mwrite_d = flush ? 1'b0 : ex_mwrite_q;
    mem_mtor_d   = flush ? 1'b0 : ex_mtor_q;
    mem_urw_d    = flush ? 1'b0 : ex_urw_q;
    wb_mtor_d    = mem_mtor_q;
    wb_urw_d     = mem_urw_q;
    illegal_d    = illegal_q | (dec_illegal & ~bubble);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_regds_q   <= 1'b0;
      ex_alusrc_q  <= 1'b0;
      ex_aop_q     <= '0;
      ex_jump_q    <= 1'b0;
      ex_branch_q  <= 1'b0;
      ex_mread_q   <= 1'b0;
      ex_mwrite_q  <= 1'b0;
      ex_mtor_q    <= 1'b0;
      ex_urw_q     <= 1'b0;
      ex_valid_q   <= 1'b0;
      ex_rt_q      <= '0;
      mem_branch_q <= 1'b0;
      mem_mread_q  <= 1'b0;
      mem_mwrite_q <= 1'b0;
      mem_mtor_q   <= 1'b0;
      mem_urw_q    <= 1'b0;
      wb_mtor_q    <= 1'b0;
      wb_urw_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      ex_regds_q   <= ex_regds_d;
      ex_alusrc_q  <= ex_alusrc_d;
      ex_aop_q     <= ex_aop_d;
      ex_jump_q    <= ex_jump_d;
      ex_branch_q  <= ex_branch_d;
      ex_mread_q   <= ex_mread_d;
      ex_mwrite_q  <= ex_mwrite_d;
      ex_mtor_q    <= ex_mtor_d;
      ex_urw_q     <= ex_urw_d;
      ex_valid_q   <= ex_valid_d;
      ex_rt_q      <= ex_rt_d;
      mem_branch_q <= mem_branch_d;
      mem_mread_q  <= mem_mread_d;
      mem_mwrite_q <= mem_mwrite_d;
      mem_mtor_q   <= mem_mtor_d;
      mem_urw_q    <= mem_urw_d;
      wb_mtor_q    <= wb_mtor_d;
      wb_urw_q     <= wb_urw_d;
      illegal_q    <= illegal_d;
    end
  end

  assign ex_regds   = ex_regds_q;
  assign ex_alusrc  = ex_alusrc_q;
  assign ex_aop     = ex_aop_q;
  assign ex_jump    = ex_jump_q;
  assign mem_branch = mem_branch_q;
  assign mem_mread  = mem_mread_q;
  assign mem_mwrite = mem_mwrite_q;
  assign wb_mtor    = wb_mtor_q;
  assign wb_urw     = wb_urw_q;
  assign illegal    = illegal_q;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed bench for pipe_ctrl_unit (JUMP_EN=1 main, JUMP_EN=0 side instance).
module tb_pipe_ctrl_unit;

  localparam logic [5:0] R    = 6'b000000;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] ANDI = 6'b001100;
  localparam logic [5:0] ORI  = 6'b001101;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] BAD  = 6'b111111;

  logic       clk, rst, id_valid, mem_zero;
  logic [5:0] id_op;
  logic [4:0] id_rs, id_rt;
  logic       ex_regds, ex_alusrc, ex_jump, mem_branch, mem_mread, mem_mwrite;
  logic       wb_mtor, wb_urw, stall, flush, illegal;
  logic [2:0] ex_aop;
  logic       z_regds, z_alusrc, z_jump, z_branch, z_mread, z_mwrite;
  logic       z_mtor, z_urw, z_stall, z_flush, z_illegal;
  logic [2:0] z_aop;

  int total = 0;
  int bad   = 0;

  pipe_ctrl_unit #(.OPW(6), .AOPW(3), .RAW(5), .JUMP_EN(1)) dut (
    .clk(clk), .rst(rst), .id_op(id_op), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .mem_zero(mem_zero), .ex_regds(ex_regds), .ex_alusrc(ex_alusrc), .ex_aop(ex_aop),
    .ex_jump(ex_jump), .mem_branch(mem_branch), .mem_mread(mem_mread), .mem_mwrite(mem_mwrite),
    .wb_mtor(wb_mtor), .wb_urw(wb_urw), .stall(stall), .flush(flush), .illegal(illegal)
  );

  pipe_ctrl_unit #(.OPW(6), .AOPW(3), .RAW(5), .JUMP_EN(0)) dut_nj (
    .clk(clk), .rst(rst), .id_op(id_op), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .mem_zero(mem_zero), .ex_regds(z_regds), .ex_alusrc(z_alusrc), .ex_aop(z_aop),
    .ex_jump(z_jump), .mem_branch(z_branch), .mem_mread(z_mread), .mem_mwrite(z_mwrite),
    .wb_mtor(z_mtor), .wb_urw(z_urw), .stall(z_stall), .flush(z_flush), .illegal(z_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [5:0] ex_obs  = {ex_regds, ex_alusrc, ex_aop, ex_jump};
  wire [2:0] mem_obs = {mem_branch, mem_mread, mem_mwrite};
  wire [1:0] wb_obs  = {wb_mtor, wb_urw};

  // Table row: {regds, branch, mread, mtor, aop[2:0], mwrite, alusrc, urw, jump}
  function automatic logic [10:0] tbl(input logic [5:0] op);
    case (op)
      R:    return {1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0};
      LW:   return {1'b0, 1'b0, 1'b1, 1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0};
      SW:   return {1'b0, 1'b0, 1'b0, 1'b0, 3'b011, 1'b1, 1'b1, 1'b0, 1'b0};
      BEQ:  return {1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0};
      ADDI: return {1'b1, 1'b0, 1'b0, 1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0};
      ANDI: return {1'b1, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 1'b1, 1'b0};
      ORI:  return {1'b1, 1'b0, 1'b0, 1'b1, 3'b110, 1'b0, 1'b1, 1'b1, 1'b0};
      SLTI: return {1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 1'b0, 1'b1, 1'b1, 1'b0};
      J:    return {1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1};
      default: return 11'd0;
    endcase
  endfunction

  function automatic logic [5:0] ex_of(input logic [10:0] t);
    return {t[10], t[2], t[6:4], t[0]};
  endfunction
  function automatic logic [2:0] mem_of(input logic [10:0] t);
    return {t[9], t[8], t[3]};
  endfunction
  function automatic logic [1:0] wb_of(input logic [10:0] t);
    return {t[7], t[1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    id_op = op; id_rs = rs; id_rt = rt; id_valid = 1'b1;
  endtask

  task automatic nop();
    id_op = R; id_rs = 5'd0; id_rt = 5'd0; id_valid = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    nop();
    for (int k = 0; k < n; k++) tick();
  endtask

  logic [5:0]  ops [7];
  logic [10:0] cur, p1, p2;

  initial begin
    rst = 1'b1; mem_zero = 1'b0;
    nop();
    tick(); tick();
    check("rst_ex", ex_obs, 0);
    check("rst_mem", mem_obs, 0);
    check("rst_wb", wb_obs, 0);
    check("rst_stall_flush_ill", {stall, flush, illegal}, 0);
    rst = 1'b0;

    // reset mid-stream with LW in EX and a dependent ADD waiting in ID
    drive(LW, 5'd1, 5'd7); tick();
    check("mid_ex_mread", {31'd0, dut.ex_mread_q}, 1);
    drive(R, 5'd7, 5'd2); #1;
    check("mid_stall_pre", stall, 1);
    rst = 1'b1; #1;
    check("mid_rst_ex", ex_obs, 0);
    check("mid_rst_mem", mem_obs, 0);
    check("mid_rst_stall", stall, 0);
    tick();
    rst = 1'b0;
    drive(ADDI, 5'd1, 5'd2); tick();
    check("post_rst_aop", ex_aop, 3'b011);
    check("post_rst_alusrc", ex_alusrc, 1);
    nop(); tick(); tick();
    check("post_rst_wb_urw", wb_urw, 1);
    idle(3);

    // hazard-free stream
    ops = '{R, LW, SW, BEQ, ANDI, ORI, SLTI};
    p1 = '0; p2 = '0;
    for (int i = 0; i < 9; i++) begin
      if (i < 7) begin
        cur = tbl(ops[i]);
        if (ops[i] == LW) drive(LW, 5'd1, 5'd9);
        else              drive(ops[i], 5'd1, 5'd2);
      end else begin
        cur = '0;
        nop();
      end
      #1;
      check($sformatf("strm%0d_stall", i), stall, 0);
      check($sformatf("strm%0d_flush", i), flush, 0);
      tick();
      check($sformatf("strm%0d_ex", i), ex_obs, ex_of(cur));
      check($sformatf("strm%0d_mem", i), mem_obs, mem_of(p1));
      check($sformatf("strm%0d_wb", i), wb_obs, wb_of(p2));
      p2 = p1; p1 = cur;
    end
    idle(3);

    // load-use: exactly one stall cycle
    drive(LW, 5'd1, 5'd5); tick();
    drive(R, 5'd5, 5'd2); #1;
    check("lu_stall", stall, 1);
    tick();
    check("lu_bubble_ex", ex_obs, 0);
    check("lu_mem_mread", mem_mread, 1);
    check("lu_stall_drop", stall, 0);
    tick();
    check("lu_add_ex", ex_obs, ex_of(tbl(R)));
    idle(3);

    // register 0 never stalls
    drive(LW, 5'd1, 5'd0); tick();
    drive(R, 5'd0, 5'd0); #1;
    check("r0_stall", stall, 0);
    tick();
    check("r0_add_ex", ex_obs, ex_of(tbl(R)));
    idle(3);

    // taken branch squashes the two younger instructions
    drive(BEQ, 5'd1, 5'd2); tick();
    drive(ADDI, 5'd1, 5'd2); tick();
    mem_zero = 1'b1;
    drive(ORI, 5'd1, 5'd2); #1;
    check("tk_flush", flush, 1);
    tick();
    mem_zero = 1'b0;
    check("tk_ex", ex_obs, 0);
    check("tk_mem", mem_obs, 0);
    check("tk_wb", wb_obs, 0);
    nop(); tick();
    check("tk_mem2", mem_obs, 0);
    check("tk_wb2", wb_obs, 0);
    tick();
    check("tk_wb3", wb_obs, 0);
    idle(2);

    // not-taken branch lets the stream through
    drive(BEQ, 5'd1, 5'd2); tick();
    drive(ADDI, 5'd1, 5'd2); tick();
    drive(ORI, 5'd1, 5'd2); #1;
    check("nt_flush", flush, 0);
    tick();
    check("nt_ex_aop", ex_aop, 3'b110);
    nop(); tick();
    check("nt_wb_addi", wb_obs, 2'b11);
    idle(3);

    // flush and stall together: flush wins
    drive(BEQ, 5'd1, 5'd2); tick();
    drive(LW, 5'd1, 5'd5); tick();
    mem_zero = 1'b1;
    drive(R, 5'd5, 5'd2); #1;
    check("fs_flush", flush, 1);
    check("fs_stall", stall, 0);
    tick();
    mem_zero = 1'b0;
    check("fs_ex", ex_obs, 0);
    check("fs_mem", mem_obs, 0);
    check("fs_stall_after", stall, 0);
    idle(3);

    // illegal opcode
    check("ill_clear", illegal, 0);
    id_op = BAD; id_rs = 5'd0; id_rt = 5'd0; id_valid = 1'b0; tick();
    check("ill_invalid", illegal, 0);
    drive(BAD, 5'd1, 5'd2); tick();
    check("ill_ex", ex_obs, 0);
    check("ill_set", illegal, 1);
    idle(3);
    check("ill_sticky", illegal, 1);
    rst = 1'b1; #1;
    check("ill_rst", illegal, 0);
    tick();
    rst = 1'b0;

    // J decoded only when JUMP_EN=1
    drive(J, 5'd0, 5'd0); tick();
    check("j_ex", ex_obs, ex_of(tbl(J)));
    check("j_ill", illegal, 0);
    check("nj_jump", z_jump, 0);
    check("nj_ill", z_illegal, 1);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Pipelined successor to the single-cycle opcode decoder for the MIPS datapath.
- Decodes the ID-stage opcode into control bits, then carries them through ID/EX, EX/MEM and MEM/WB control registers.
- Detects load-use hazards and inserts bubbles.
- Flushes younger instructions on a taken branch.
- Flags illegal opcodes instead of driving X.

Parameters:
- OPW, 6, opcode width.
- AOPW, 3, ALU-op code width.
- RAW, 5, register-address width.
- JUMP_EN, 0, when 1 decodes J (6'b000010) and drives ex_jump; when 0, J is illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- id_op  in  OPW  opcode of the instruction in ID.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  RAW  rs field in ID.
- id_rt  in  RAW  rt field in ID.
- mem_zero  in  1  ALU zero flag registered into MEM.
- ex_regds, ex_alusrc  out  1  EX-stage controls.
- ex_aop  out  AOPW  EX-stage ALU op.
- ex_jump  out  1  EX-stage jump (0 when JUMP_EN=0).
- mem_branch, mem_mread, mem_mwrite  out  1  MEM-stage controls.
- wb_mtor, wb_urw  out  1  WB-stage controls.
- stall  out  1  comb.; hold PC and IF/ID, bubble into ID/EX.
- flush  out  1  comb.; = mem_branch & mem_zero.
- illegal  out  1  registered; sticky illegal-opcode flag.

Behaviour:
- Decode (comb.), fields RegDs/Branch/MRead/MtoR/AOp/MWrite/ALUsrc/Urw:
  - R 000000: 1/0/0/1/010/0/0/1.
  - LW 100011: 0/0/1/1/011/0/1/1.
  - SW 101011: 0/0/0/0/011/1/1/0.
  - BEQ 000100: 0/1/0/0/001/0/0/0.
  - ADDI 001000: 1/0/0/1/011/0/1/1.
  - ANDI 001100: AOp 101, otherwise as ADDI.
  - ORI 001101: AOp 110, otherwise as ADDI.
  - SLTI 001010: AOp 100, otherwise as ADDI.
  - J 000010 (JUMP_EN=1): all 0 except jump=1, AOp 000.
  - Any other opcode: all zeros (NOP); raises illegal if id_valid.
  - id_valid=0 decodes as NOP.
- Internal state: ID/EX also registers rt (ex_rt) and validity.
- Pipeline: every rising edge, ID/EX <= decoded or bubble; EX/MEM <= ID/EX controls; MEM/WB <= EX/MEM controls.
- Latency: ID decode to ex_* is 1 cycle, to mem_* 2 cycles, to wb_* 3 cycles.
- Load-use: stall = ex_mread & id_valid & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt).
  - While stall=1, ID/EX loads bubble (all zeros); older stages keep advancing.
  - stall deasserts the cycle after the load leaves EX (exactly 1 stall cycle per hazard).
- Flush: when flush=1, next edge loads bubble into ID/EX and EX/MEM.
  - MEM/WB captures the branch's own (zero write) controls normally.
  - stall is forced 0 while flush=1 (flush has priority).
- illegal: sets on the edge where an illegal opcode is loaded into ID/EX (not stalled, not flushed); cleared only by rst.
- Reset: all stage registers and illegal = 0 immediately on rst rise. All outputs are therefore 0 (stall and flush 0 follow combinationally). Reset mid-stream drops all in-flight controls; first decode after rst release appears on ex_* after 1 edge.
- Width rules: all equality compares are RAW bits, unsigned; register 0 never causes a stall.
- Illegal-opcode decoding never produces X on any output.

Test Plan:
- Reset: assert rst mid-stream with LW in EX -> all outputs 0 within same cycle, stall=0; release, feed ADDI -> ex_aop=011, ex_alusrc=1 after 1 edge, wb_urw=1 after 3 edges.
- Stream R, LW, SW, BEQ, ANDI, ORI, SLTI (no hazards) -> each tuple appears per table on ex_/mem_/wb_ at +1/+2/+3 cycles; stall and flush stay 0.
- LW rt=5 then ADD rs=5 -> stall=1 for exactly one cycle, ex_* all 0 next cycle, ADD controls on ex_* one cycle later.
- LW rt=0 then ADD rs=0 -> stall stays 0.
- BEQ with mem_zero=1 when it reaches MEM -> flush=1; following two instructions' controls never reach mem_/wb_ (all 0).
- Same BEQ with mem_zero=0 -> no flush, stream continues.
- Flush and stall in the same cycle -> stall=0, flush wins.
- Opcode 111111 with id_valid=1 -> ex_* all 0, illegal=1 and stays 1 until rst.
- J with JUMP_EN=1 -> ex_jump=1.
- J with JUMP_EN=0 -> illegal=1.
